paged_mem_ctrl: RTL
===================

// Module: paged_mem_ctrl
// PURPOSE
//  Parametrised memory sequencer and pager for the BBC system bus. Time-slices one
//  single-port physical memory between the video fetcher and the 6502. Owns the
//  paged-ROM select (ROMSEL), sideways-RAM write enables and B+-style shadow RAM
//  (ACCCON). Sits between the bus decode and the RAM/ROM arrays, and generalises
//  the fixed two-ROM pager to N banks with writable banks and shadow paging.
// PARAMETERS
//  NUM_BANKS   16        number of sideways banks (power of 2, 2..16); BW = clog2(NUM_BANKS)
//  ROM_PRESENT 16'h0003  bit i=1: bank i is populated; unpopulated banks read 8'hFF
//  SWRAM_MASK  16'h00F0  bit i=1: bank i is writable sideways RAM (implies present)
//  SHADOW_EN   1         1: ACCCON shadow paging implemented; 0: ACCCON reads/acts as 0
// PORTS
//  clk          in   1   system clock (PIXELCLK domain)
//  RESET        in   1   synchronous, active-high reset
//  clk_en       in   1   slot strobe (RAM_en); one memory slot per pulse
//  V_TURN       in   1   1: current slot belongs to video, 0: to the CPU
//  PHI_2        in   1   CPU phase 2; CPU writes are committed only when high
//  pADDR        in   16  CPU address bus
//  RnW          in   1   CPU read(1)/write(0)
//  pDIN         in   8   CPU write data
//  ROMSEL_we    in   1   decoded &FE30 write strobe
//  ACCCON_we    in   1   decoded &FE34 write strobe
//  pDOUT        out  8   CPU read data (registered, held until next CPU read)
//  pVALID       out  1   1-clk pulse: pDOUT updated
//  vADDR        in   15  video (CRTC-corrected) address
//  vDOUT        out  8   video read data (registered)
//  vVALID       out  1   1-clk pulse: vDOUT updated
//  ROM_BANK     out  BW  current ROMSEL value
//  ACCCON       out  2   [0] video from shadow, [1] CPU 3000-7FFF to shadow
//  WP_FAULT     out  1   1-clk pulse: write to read-only region discarded
//  mem_rgn      out  2   0 main RAM, 1 shadow RAM, 2 OS ROM, 3 sideways bank
//  mem_bank     out  BW  bank index when mem_rgn==3
//  mem_off      out  15  offset within region (bank/OS use [13:0])
//  mem_we       out  1   write strobe to physical memory (single clk)
//  mem_wdata    out  8   write data
//  mem_rdata    in   8   read data, valid 1 clk after issue (sync BRAM)
// BEHAVIOUR
//  Reset: ROM_BANK=0, ACCCON=0, pDOUT=vDOUT=8'h00, pVALID=vVALID=WP_FAULT=0,
//   mem_we=0, mem_rgn=0, mem_bank=0, mem_off=0, FSM=IDLE, pending slot cleared.
//   Reset mid-operation aborts the slot; no valid pulse; an issued write is never repeated.
//  Registers: on clk_en & ROMSEL_we: ROM_BANK<=pDIN[BW-1:0]. On clk_en & ACCCON_we:
//   ACCCON<=SHADOW_EN?pDIN[1:0]:0. Both take effect from the next slot.
//  CPU decode: 0000-2FFF main; 3000-7FFF shadow if ACCCON[1] else main;
//   8000-BFFF bank ROM_BANK; C000-FBFF, FF00-FFFF OS (off=A[13:0]); FC00-FEFF unclaimed:
//   no memory cycle issued, pVALID not pulsed, pDOUT held.
//  Video decode: rgn = ACCCON[0]?shadow:main, off=vADDR.
//  FSM: IDLE -clk_en&V_TURN-> VISSUE; IDLE -clk_en&~V_TURN-> CISSUE; *ISSUE -> CAPT -> IDLE.
//   VISSUE/CISSUE drive mem_* for exactly 1 clk; CAPT registers mem_rdata and pulses
//   vVALID or pVALID. Latency clk_en -> valid = 2 clks.
//  clk_en arriving in ISSUE or CAPT: slot (with its V_TURN) is latched as pending and
//   started from IDLE next clk; a second collision overwrites pending (newest wins).
//  CPU write (CISSUE, RnW=0, PHI_2=1): mem_we=1 only for RAM, shadow, or a bank with
//   SWRAM_MASK bit set; OS or non-SWRAM bank -> mem_we=0, WP_FAULT pulses in CAPT.
//   Write with PHI_2=0: no memory cycle. Writes never pulse pVALID.
//  CPU read of unpopulated bank: no mem read; pDOUT<=8'hFF with pVALID in CAPT.
// TESTING
//  ROMSEL_we pDIN=8'h05 then read &8123 -> mem_rgn=3, mem_bank=5, mem_off=14'h0123.
//  Write 8'hA5 to &9000 bank 4 (SWRAM) PHI_2=1 -> mem_we pulse; bank 0 -> WP_FAULT, no mem_we.
//  ACCCON=2'b10, read &3000 -> rgn=1; &2FFF -> rgn=0; vADDR with ACCCON[0]=0 -> rgn=0.
//  Read bank 9 (absent) -> pVALID 2 clks after clk_en, pDOUT=8'hFF; read &FE40 -> no pVALID.
//  clk_en on consecutive clks (V then C) -> vVALID at t+2, pVALID at t+4, both correct.
//  RESET during CISSUE write -> mem_we deasserted next clk, no pVALID, ROM_BANK=0.

Source files
------------

// File: rtl/paged_mem_ctrl.sv
// Memory sequencer and pager: time-slices one single-port memory between video and CPU,
// and owns the sideways ROMSEL bank select, sideways-RAM write enables and ACCCON shadow paging.
module paged_mem_ctrl #(
    parameter int          NUM_BANKS   = 16,
    parameter logic [15:0] ROM_PRESENT = 16'h0003,
    parameter logic [15:0] SWRAM_MASK  = 16'h00F0,
    parameter bit          SHADOW_EN   = 1'b1,
    localparam int         BW          = $clog2(NUM_BANKS)
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          clk_en,
    input  logic          V_TURN,
    input  logic          PHI_2,
    input  logic [15:0]   pADDR,
    input  logic          RnW,
    input  logic [7:0]    pDIN,
    input  logic          ROMSEL_we,
    input  logic          ACCCON_we,
    output logic [7:0]    pDOUT,
    output logic          pVALID,
    input  logic [14:0]   vADDR,
    output logic [7:0]    vDOUT,
    output logic          vVALID,
    output logic [BW-1:0] ROM_BANK,
    output logic [1:0]    ACCCON,
    output logic          WP_FAULT,
    output logic [1:0]    mem_rgn,
    output logic [BW-1:0] mem_bank,
    output logic [14:0]   mem_off,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_VISSUE, S_CISSUE, S_CAPT} state_e;
    typedef enum logic [1:0] {RGN_MAIN = 2'd0, RGN_SHADOW = 2'd1, RGN_OS = 2'd2, RGN_BANK = 2'd3} rgn_e;
    // What the capture cycle must do for the slot in flight.
    typedef enum logic [2:0] {OP_NONE, OP_VREAD, OP_CREAD, OP_CFF, OP_WPF} op_e;

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic          pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [BW-1:0] rom_bank_q, rom_bank_d;
    logic [1:0]    acccon_q, acccon_d;
    logic [7:0]    pdout_q, pdout_d;
    logic          pvalid_q, pvalid_d;
    logic [7:0]    vdout_q, vdout_d;
    logic          vvalid_q, vvalid_d;
    logic          wp_fault_q, wp_fault_d;
    rgn_e          mem_rgn_q, mem_rgn_d;
    logic [BW-1:0] mem_bank_q, mem_bank_d;
    logic [14:0]   mem_off_q, mem_off_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;

    rgn_e          cpu_rgn;
    logic [14:0]   cpu_off;
    logic          cpu_claimed;
    logic          cpu_writable;
    logic          bank_present;
    logic          start;
    logic          start_v;

    always_comb begin
        cpu_rgn     = RGN_MAIN;
        cpu_off     = pADDR[14:0];
        cpu_claimed = 1'b1;
        if (!pADDR[15]) begin
            if (pADDR[14:12] >= 3'd3 && acccon_q[1]) cpu_rgn = RGN_SHADOW;
        end else if (!pADDR[14]) begin
            cpu_rgn = RGN_BANK;
            cpu_off = {1'b0, pADDR[13:0]};
        end else if (pADDR[15:8] inside {8'hFC, 8'hFD, 8'hFE}) begin
            cpu_claimed = 1'b0;
        end else begin
            cpu_rgn = RGN_OS;
            cpu_off = {1'b0, pADDR[13:0]};
        end
        bank_present = ROM_PRESENT[rom_bank_q] | SWRAM_MASK[rom_bank_q];
        cpu_writable = (cpu_rgn == RGN_MAIN) || (cpu_rgn == RGN_SHADOW) ||
                       (cpu_rgn == RGN_BANK && SWRAM_MASK[rom_bank_q]);
    end

    // NOTE: every variable gets its default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        rom_bank_d  = rom_bank_q;
        acccon_d    = acccon_q;
        pdout_d     = pdout_q;
        pvalid_d    = 1'b0;
        vdout_d     = vdout_q;
        vvalid_d    = 1'b0;
        wp_fault_d  = 1'b0;
        mem_rgn_d   = mem_rgn_q;
        mem_bank_d  = mem_bank_q;
        mem_off_d   = mem_off_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        start       = 1'b0;
        start_v     = 1'b0;

        if (clk_en && ROMSEL_we) rom_bank_d = pDIN[BW-1:0];
        if (clk_en && ACCCON_we) acccon_d = SHADOW_EN ? pDIN[1:0] : 2'b00;

        case (state_q)
            S_IDLE: begin
                if (clk_en) begin
                    start   = 1'b1;
                    start_v = V_TURN;
                    pend_d  = 1'b0;
                end else if (pend_q) begin
                    start   = 1'b1;
                    start_v = pend_v_q;
                    pend_d  = 1'b0;
                end
            end
            S_VISSUE, S_CISSUE: begin
                state_d = S_CAPT;
                if (clk_en) begin
                    pend_d   = 1'b1;
                    pend_v_d = V_TURN;
                end
            end
            S_CAPT: begin
                state_d = S_IDLE;
                case (op_q)
                    OP_VREAD: begin vdout_d = mem_rdata; vvalid_d = 1'b1; end
                    OP_CREAD: begin pdout_d = mem_rdata; pvalid_d = 1'b1; end
                    OP_CFF:   begin pdout_d = 8'hFF;     pvalid_d = 1'b1; end
                    OP_WPF:   wp_fault_d = 1'b1;
                    default:  ;
                endcase
                // A slot that collided with the one just finished starts straight away.
                if (pend_q) begin
                    start   = 1'b1;
                    start_v = pend_v_q;
                    pend_d  = 1'b0;
                end
                if (clk_en) begin
                    pend_d   = 1'b1;
                    pend_v_d = V_TURN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d = start_v ? S_VISSUE : S_CISSUE;
            op_d    = OP_NONE;
            if (start_v) begin
                op_d      = OP_VREAD;
                mem_rgn_d = acccon_q[0] ? RGN_SHADOW : RGN_MAIN;
                mem_off_d = vADDR;
            end else if (cpu_claimed && RnW) begin
                if (cpu_rgn == RGN_BANK && !bank_present) begin
                    op_d = OP_CFF;
                end else begin
                    op_d       = OP_CREAD;
                    mem_rgn_d  = cpu_rgn;
                    mem_bank_d = rom_bank_q;
                    mem_off_d  = cpu_off;
                end
            end else if (cpu_claimed && PHI_2) begin
                if (cpu_writable) begin
                    mem_rgn_d   = cpu_rgn;
                    mem_bank_d  = rom_bank_q;
                    mem_off_d   = cpu_off;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = pDIN;
                end else begin
                    op_d = OP_WPF;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NONE;
            pend_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            rom_bank_q  <= '0;
            acccon_q    <= 2'b00;
            pdout_q     <= 8'h00;
            pvalid_q    <= 1'b0;
            vdout_q     <= 8'h00;
            vvalid_q    <= 1'b0;
            wp_fault_q  <= 1'b0;
            mem_rgn_q   <= RGN_MAIN;
            mem_bank_q  <= '0;
            mem_off_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            rom_bank_q  <= rom_bank_d;
            acccon_q    <= acccon_d;
            pdout_q     <= pdout_d;
            pvalid_q    <= pvalid_d;
            vdout_q     <= vdout_d;
            vvalid_q    <= vvalid_d;
            wp_fault_q  <= wp_fault_d;
            mem_rgn_q   <= mem_rgn_d;
            mem_bank_q  <= mem_bank_d;
            mem_off_q   <= mem_off_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign pDOUT     = pdout_q;
    assign pVALID    = pvalid_q;
    assign vDOUT     = vdout_q;
    assign vVALID    = vvalid_q;
    assign ROM_BANK  = rom_bank_q;
    assign ACCCON    = acccon_q;
    assign WP_FAULT  = wp_fault_q;
    assign mem_rgn   = mem_rgn_q;
    assign mem_bank  = mem_bank_q;
    assign mem_off   = mem_off_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule
